// File: rtl/adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// adder_share_ctrl
//   Time-shares one external combinational adder between two requesters.
//   A request is accepted in IDLE (round-robin on ties), its operands are
//   latched and presented to the adder for SETTLE cycles, then the adder
//   result is captured into sum/cout and handed back with a done pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/req1             level requests
//   a0/a1, b0/b1          operands per requester
//   cin0/cin1             carry-in per requester
//   gnt0/gnt1             1-cycle pulse: request accepted, operands latched
//   done0/done1           1-cycle pulse: sum/cout valid for that requester
//   sum, cout             captured result, held until next capture
//   adder_a/b/cin         operands driven to the shared adder
//   adder_s, adder_cout   result returned by the shared adder
//   busy                  high while a transaction is in flight (WAIT/DONE)
// ---------------------------------------------------------------------------
module adder_share_ctrl #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_s,
    input  logic             adder_cout,
    output logic             busy
);

    // Counter only needs to hold SETTLE-1.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_op_cin;
    logic             r_win;      // owner of the current transaction
    logic             r_rr;       // last served requester
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;

    logic             w_any;
    logic             w_win;

    // Arbitration: sole requester wins; on a tie the one that was not
    // served last wins (r_rr resets to 1 so requester 0 takes the first tie).
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_rr : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_cin <= 1'b0;
            r_win    <= 1'b0;
            r_rr     <= 1'b1;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // Pulses default low; set for a single cycle below.
            r_gnt  <= 2'b00;
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= w_win ? a1   : a0;
                        r_op_b   <= w_win ? b1   : b0;
                        r_op_cin <= w_win ? cin1 : cin0;
                        r_win    <= w_win;
                        r_gnt    <= w_win ? 2'b10 : 2'b01;
                        r_cnt    <= CW'(SETTLE - 1);
                        r_busy   <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Requests are ignored here; the adder inputs settle.
                    if (r_cnt == '0) begin
                        r_sum   <= adder_s;
                        r_cout  <= adder_cout;
                        r_done  <= r_win ? 2'b10 : 2'b01;
                        r_rr    <= r_win;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Adder inputs come straight from the operand registers, so they stay
    // put in IDLE and do not toggle until the next accept.
    assign adder_a   = r_op_a;
    assign adder_b   = r_op_b;
    assign adder_cin = r_op_cin;

    assign gnt0  = r_gnt[0];
    assign gnt1  = r_gnt[1];
    assign done0 = r_done[0];
    assign done1 = r_done[1];
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign busy  = r_busy;

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] a0, a1, b0, b1;
    logic         cin0, cin1;
    logic         gnt0, gnt1, done0, done1;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] adder_a, adder_b;
    logic         adder_cin;
    logic [W-1:0] adder_s;
    logic         adder_cout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit           who;
        logic [W-1:0] s;
        logic         c;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // External shared adder
    assign {adder_cout, adder_s} = 17'(adder_a) + 17'(adder_b) + 17'(adder_cin);

    adder_share_ctrl #(.WIDTH(W), .SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .sum(sum), .cout(cout),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_s(adder_s), .adder_cout(adder_cout),
        .busy(busy)
    );

    function automatic exp_t model(input bit who, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] r;
        r = 17'(a) + 17'(b) + 17'(c);
        e.who = who;
        e.s   = r[W-1:0];
        e.c   = r[W];
        return e;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0; a0 = '0; a1 = '0; b0 = '0; b1 = '0; cin0 = 0; cin1 = 0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt1, gnt0, done1, done0, busy, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b cout=%b sum=%h, want all 0",
                     {gnt1, gnt0}, {done1, done0}, busy, cout, sum);
        end
        n_tests++;
        if ({adder_a, adder_b, adder_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset_adder: got a=%h b=%h cin=%b, want 0", adder_a, adder_b, adder_cin);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({gnt1, gnt0, done1, done0, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got gnt=%b done=%b busy=%b, want 0", {gnt1, gnt0}, {done1, done0}, busy);
        end
    endtask

    // One isolated transaction from a single requester.
    task automatic test_single(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic [W-1:0] es, input logic ec);
        exp_t e;
        bit   seen, hold_ok, pulse_ok;
        int   ncyc;
        @(negedge clk);
        if (who) begin req1 = 1; a1 = a; b1 = b; cin1 = c; end
        else     begin req0 = 1; a0 = a; b0 = b; cin0 = c; end
        sb.push_back('{who, es, ec});
        @(negedge clk);
        n_tests++;
        if ({gnt1, gnt0} !== (who ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL gnt_single%0d: got %b want %b", who, {gnt1, gnt0}, who ? 2'b10 : 2'b01);
        end
        // Requester releases and scrambles its operands after the grant.
        req0 = 0; req1 = 0;
        a0 = ~a; b0 = ~b; cin0 = ~c; a1 = ~a; b1 = ~b; cin1 = ~c;
        seen = 0; hold_ok = 1; pulse_ok = 1; ncyc = 1;
        while (!seen && ncyc < 20) begin
            if (adder_a !== a || adder_b !== b || adder_cin !== c) hold_ok = 0;
            if (ncyc > 1 && (gnt0 | gnt1)) pulse_ok = 0;
            if (busy !== 1'b1) pulse_ok = 0;
            if (done0 | done1) seen = 1;
            else begin @(negedge clk); ncyc++; end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout%0d: no done within %0d cycles", who, ncyc);
        end else begin
            n_tests++;
            if (ncyc != 5) begin
                n_fail++;
                $display("FAIL done_latency%0d: got %0d cycles want 5", who, ncyc);
            end
            n_tests++;
            if ({done1, done0} !== (who ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL done_owner%0d: got %b want %b", who, {done1, done0}, who ? 2'b10 : 2'b01);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (sum !== e.s || cout !== e.c) begin
                    n_fail++;
                    $display("FAIL result%0d: got cout=%b sum=%h want cout=%b sum=%h", who, cout, sum, e.c, e.s);
                end
            end
        end
        n_tests++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL adder_hold%0d: adder inputs moved, now a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                     who, adder_a, adder_b, adder_cin, a, b, c);
        end
        n_tests++;
        if (!pulse_ok) begin
            n_fail++;
            $display("FAIL pulse_busy%0d: extra gnt or busy low during transaction", who);
        end
        @(negedge clk);
        n_tests++;
        if ({done1, done0, busy} !== 3'b0 || sum !== es || cout !== ec) begin
            n_fail++;
            $display("FAIL after_done%0d: got done=%b busy=%b sum=%h cout=%b want 0,0,%h,%b",
                     who, {done1, done0}, busy, sum, cout, es, ec);
        end
    endtask

    // Simultaneous first requests after reset: req0 wins, then req1.
    task automatic test_tie_after_reset();
        exp_t e;
        int   ncyc, ndone, gidx, idle_cnt;
        bit   order_ok;
        apply_reset();
        @(negedge clk);
        req0 = 1; a0 = 16'h1234; b0 = 16'h1111; cin0 = 0;
        req1 = 1; a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1;
        sb.push_back('{1'b0, 16'h2345, 1'b0});
        sb.push_back('{1'b1, 16'h0000, 1'b1});
        ncyc = 0; ndone = 0; gidx = 0; idle_cnt = 0; order_ok = 1;
        while (ndone < 2 && ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            if (gnt0 & gnt1) order_ok = 0;
            if (gnt0 | gnt1) begin
                if (gnt1 !== (gidx == 1)) order_ok = 0;
                gidx++;
                if (gnt0) req0 = 0;
                if (gnt1) req1 = 0;
            end
            if (!busy) idle_cnt++;
            if (done0 | done1) begin
                ndone++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++;
                    if (done1 !== e.who || done0 === done1 || sum !== e.s || cout !== e.c) begin
                        n_fail++;
                        $display("FAIL tie_result: got done=%b sum=%h cout=%b want owner %0d sum=%h cout=%b",
                                 {done1, done0}, sum, cout, e.who, e.s, e.c);
                    end
                end
            end
        end
        n_tests++;
        if (ndone != 2) begin
            n_fail++;
            $display("FAIL tie_timeout: got %0d dones want 2", ndone);
        end
        n_tests++;
        if (!order_ok || gidx != 2) begin
            n_fail++;
            $display("FAIL tie_order: got %0d grants (order ok=%0d) want 0 then 1", gidx, order_ok);
        end
        n_tests++;
        if (idle_cnt != 1) begin
            n_fail++;
            $display("FAIL tie_busy: got %0d idle cycles between, want 1", idle_cnt);
        end
    endtask

    // Both requesters held high: grants alternate, one result per 6 cycles.
    task automatic test_back_to_back();
        exp_t e;
        int   ncyc, ndone, gidx, last_done;
        bit   alt_ok, space_ok;
        apply_reset();
        @(negedge clk);
        req0 = 1; a0 = 16'h8000; b0 = 16'h8000; cin0 = 1;
        req1 = 1; a1 = 16'h00FF; b1 = 16'h0001; cin1 = 0;
        for (int i = 0; i < 4; i++)
            sb.push_back((i % 2 == 0) ? model(1'b0, a0, b0, cin0) : model(1'b1, a1, b1, cin1));
        ncyc = 0; ndone = 0; gidx = 0; last_done = 0; alt_ok = 1; space_ok = 1;
        while (ndone < 4 && ncyc < 60) begin
            @(negedge clk);
            ncyc++;
            if (gnt0 & gnt1) alt_ok = 0;
            if (gnt0 | gnt1) begin
                if (gnt1 !== (gidx % 2 == 1)) alt_ok = 0;
                gidx++;
                if (gidx == 4) begin req0 = 0; req1 = 0; end
            end
            if (done0 | done1) begin
                if (ndone > 0 && ncyc - last_done != 6) space_ok = 0;
                last_done = ncyc;
                ndone++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++;
                    if (done1 !== e.who || done0 === done1 || sum !== e.s || cout !== e.c) begin
                        n_fail++;
                        $display("FAIL b2b_result%0d: got done=%b sum=%h cout=%b want owner %0d sum=%h cout=%b",
                                 ndone, {done1, done0}, sum, cout, e.who, e.s, e.c);
                    end
                end
            end
        end
        n_tests++;
        if (ndone != 4 || !alt_ok || gidx != 4) begin
            n_fail++;
            $display("FAIL b2b_grants: got %0d dones %0d grants alt=%0d want 4,4,1", ndone, gidx, alt_ok);
        end
        n_tests++;
        if (!space_ok) begin
            n_fail++;
            $display("FAIL b2b_spacing: done spacing not 6 cycles (last at %0d)", last_done);
        end
        gidx = 0;
        repeat (8) begin
            @(negedge clk);
            if (gnt0 | gnt1 | done0 | done1) gidx++;
        end
        n_tests++;
        if (gidx != 0) begin
            n_fail++;
            $display("FAIL b2b_quiet: got %0d pulse cycles after release want 0", gidx);
        end
    endtask

    // Reset in the middle of WAIT abandons the transaction.
    task automatic test_reset_mid();
        int spurious;
        @(negedge clk);
        req0 = 1; a0 = 16'h1111; b0 = 16'h2222; cin0 = 0;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt1, gnt0, done1, done0, busy, cout, sum, adder_a, adder_b, adder_cin} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b sum=%h cout=%b adder_a=%h adder_b=%h want 0",
                     busy, sum, cout, adder_a, adder_b);
        end
        spurious = 0;
        repeat (2) begin @(negedge clk); if (done0 | done1) spurious++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (done0 | done1 | busy) spurious++; end
        n_tests++;
        if (spurious != 0 || sum !== '0 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abandon: got %0d spurious cycles sum=%h cout=%b want 0", spurious, sum, cout);
        end
        test_single(1'b0, 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single(1'b0, 16'h246B, 16'h0C15, 1'b0, 16'h3080, 1'b0);
        test_single(1'b1, 16'h3080, 16'hFDE8, 1'b0, 16'h2E68, 1'b1);
        test_tie_after_reset();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
